countdown_timer: RTL and testbench
==================================

# countdown_timer

Loadable down-counter that counts N enabled clock cycles and then raises a held expiry event. It is the counterpart of the free-running cycle-count timer: that block measures elapsed cycles, while this one produces a deadline of a chosen length. Control logic uses it for timeouts, pacing and watchdogs. The block has a valid/ready load port, a valid/ready expiry port, and supports pause and cancel.

## Interface
- TIMER_SIZE, 32, width of the load value and of the remaining-count register.
- clock  input  1  single clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset; the block is held in reset while reset = 0.
- enable  input  1  count qualifier; RUNNING decrements only in cycles with enable = 1.
- cancel  input  1  abort; forces IDLE.
- load_valid  input  1  a load request is present.
- load_ready  output  1  the block accepts a load this cycle.
- load_count  input  TIMER_SIZE  number of enabled cycles to count.
- busy  output  1  high in RUNNING or EXPIRED.
- remaining  output  TIMER_SIZE  enabled cycles left until expiry.
- expired_valid  output  1  expiry event pending.
- expired_ready  input  1  consumer acknowledges the expiry event.

## Operation
- States:
  - IDLE
  - RUNNING
  - EXPIRED
- Reset values: state = IDLE, remaining = 0, load_ready = 1, busy = 0, expired_valid = 0, internal reload register = 0.
- load_ready = (state == IDLE) & ~cancel. This is combinational from state and cancel only.
- A load is accepted when load_valid & load_ready:
  - remaining <= load_count.
  - reload register <= load_count.
  - If load_count > 0, state <= RUNNING; if load_count = 0, state <= EXPIRED.
- RUNNING with enable = 1:
  - remaining <= remaining − 1.
  - If remaining == 1, state <= EXPIRED.
- RUNNING with enable = 0: hold state and remaining.
- remaining never wraps below 0. The maximum count is 2^TIMER_SIZE − 1.
- EXPIRED: expired_valid = 1 and remaining = 0. The state holds until expired_valid & expired_ready, then:
  - goes to IDLE (default), or
  - reloads (see Configuration).
- enable does not gate the acknowledge.
- cancel = 1 in any state, on the next edge: state <= IDLE, remaining <= 0, and no expiry is produced.
- cancel has priority over:
  - a final decrement,
  - a load,
  - an acknowledge in the same cycle.
- busy = (state != IDLE). expired_valid = (state == EXPIRED). Both are decoded from the registered state; there are no combinational paths from inputs to these outputs.

## Timing
- Load accepted at edge t with load_count = N ≥ 1 and enable held high:
  - remaining = N after edge t.
  - Then N−1, …, 1.
  - expired_valid rises after edge t+N, exactly N enabled cycles after acceptance.
- N = 0: expired_valid is high after edge t, with no counting cycles.
- Cycles with enable low stretch the deadline one cycle each. remaining is frozen during those cycles.
- Acknowledge in the first EXPIRED cycle: expired_valid is high for exactly one cycle, and load_ready returns the next cycle (default build).
- Back-to-back loads: at best one load every N+2 cycles (load, N counts, 1 acknowledge cycle).
- Reset asserted mid-count clears all state immediately and asynchronously. Counting resumes only after a new load following reset release.

## Configuration
- COUNTDOWN_TIMER_AUTO_RELOAD_EN
  - Defined: an acknowledge in EXPIRED sets remaining <= reload register and returns to RUNNING. A zero reload returns to EXPIRED. load_ready stays 0 until cancel. The result is a periodic event every N enabled cycles plus acknowledge wait.
  - Undefined: an acknowledge returns to IDLE and the reload register is unused (it may be optimised away).
  - The port list is identical in both builds.

## Test plan
- Reset low for 3 cycles, then release; idle with load_valid = 0 → load_ready = 1, busy = 0, remaining = 0, expired_valid = 0.
- Load 5 with enable = 1 and expired_ready = 1 → remaining 5,4,3,2,1, then expired_valid for 1 cycle at acceptance + 5, then load_ready = 1.
- Load 4 with enable toggling 1,0,1,0,… → expiry after 7 cycles; remaining holds during the cycles with enable = 0.
- Load 0 → expired_valid the cycle after acceptance. Hold expired_ready = 0 for 10 cycles → expired_valid stays high, and load_valid is refused (load_ready = 0).
- Load 3; assert cancel on the cycle where remaining = 1 → next cycle IDLE, remaining = 0, expired_valid never asserted. Also, load_valid plus cancel while in IDLE → no load accepted.
- With COUNTDOWN_TIMER_AUTO_RELOAD_EN defined: load 2 with expired_ready = 1 → expired_valid pulses at +2, +5, +8 (period 3). Then cancel → IDLE with no further pulses. Reset low mid-count → all outputs return to their reset values immediately.

Source files
------------

// File: rtl/countdown_timer.sv
// -----------------------------------------------------------------------------
// countdown_timer
//
// Loadable down-counter. A load of N starts a countdown of N enabled clock
// cycles; when it reaches zero the block raises a held expiry event that stays
// pending until the consumer acknowledges it. Used for timeouts, pacing and
// watchdogs. cancel aborts the countdown from any state.
//
// Optional feature macro: COUNTDOWN_TIMER_AUTO_RELOAD_EN
//   defined   - acknowledging the expiry restarts the countdown from the last
//               loaded value, giving a periodic event; only cancel returns the
//               block to IDLE.
//   undefined - acknowledging the expiry returns the block to IDLE.
//   The port list is identical in both builds.
//
// Ports
//   clock          in   single clock, rising edge
//   reset          in   asynchronous, active-low reset
//   enable         in   count qualifier; RUNNING decrements only when high
//   cancel         in   abort; forces IDLE on the next edge, highest priority
//   load_valid     in   load request present
//   load_ready     out  block accepts a load this cycle (IDLE and no cancel)
//   load_count     in   number of enabled cycles to count
//   busy           out  high in RUNNING or EXPIRED
//   remaining      out  enabled cycles left until expiry
//   expired_valid  out  expiry event pending
//   expired_ready  in   consumer acknowledges the expiry event
// -----------------------------------------------------------------------------
module countdown_timer #(
    parameter int TIMER_SIZE = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  cancel,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [TIMER_SIZE-1:0] load_count,
    output logic                  busy,
    output logic [TIMER_SIZE-1:0] remaining,
    output logic                  expired_valid,
    input  logic                  expired_ready
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        EXPIRED = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [TIMER_SIZE-1:0] remaining_q, remaining_d;

`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
    logic [TIMER_SIZE-1:0] reload_q, reload_d;
`endif

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: registers are updated with non-blocking assignments so every
    // flop samples the values from before the edge, independent of the
    // order in which the simulator evaluates the always blocks.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
        end
    end

`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            reload_q <= '0;
        end else begin
            reload_q <= reload_d;
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every signal written here receives a default first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
        reload_d    = reload_q;
`endif

        if (cancel) begin
            // Cancel wins over a final decrement, a load and an acknowledge.
            state_d     = IDLE;
            remaining_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (load_valid) begin
                        remaining_d = load_count;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
                        reload_d    = load_count;
`endif
                        // A zero load expires immediately, with no counting cycles.
                        state_d     = (load_count == '0) ? EXPIRED : RUNNING;
                    end
                end

                RUNNING: begin
                    // remaining is at least 1 while RUNNING, so this never wraps.
                    if (enable) begin
                        remaining_d = remaining_q - TIMER_SIZE'(1);
                        if (remaining_q == TIMER_SIZE'(1)) begin
                            state_d = EXPIRED;
                        end
                    end
                end

                EXPIRED: begin
                    // The acknowledge is deliberately not qualified by enable.
                    if (expired_ready) begin
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
                        remaining_d = reload_q;
                        state_d     = (reload_q == '0) ? EXPIRED : RUNNING;
`else
                        state_d     = IDLE;
`endif
                    end
                end

                default: begin
                    state_d     = IDLE;
                    remaining_d = '0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // busy and expired_valid decode only the registered state; load_ready is
    // the single output with a combinational input path (through cancel).
    assign load_ready    = (state_q == IDLE) && !cancel;
    assign busy          = (state_q != IDLE);
    assign expired_valid = (state_q == EXPIRED);
    assign remaining     = remaining_q;

endmodule

// File: tb/tb_countdown_timer.sv
// -----------------------------------------------------------------------------
// tb_countdown_timer
//
// Self-checking bench for countdown_timer. A behavioural model of the timer
// (armed / fired flags plus an integer count) is advanced on every clock edge
// from the same inputs as the DUT; a compare process checks all outputs
// against it on every falling edge. Directed sequences add hand-computed
// literal expectations, followed by a randomized phase.
// Inputs are driven 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_countdown_timer;

    localparam int W = 32;

    logic         clock         = 1'b0;
    logic         reset         = 1'b0;
    logic         enable        = 1'b0;
    logic         cancel        = 1'b0;
    logic         load_valid    = 1'b0;
    logic         load_ready;
    logic [W-1:0] load_count    = '0;
    logic         busy;
    logic [W-1:0] remaining;
    logic         expired_valid;
    logic         expired_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    countdown_timer #(.TIMER_SIZE(W)) dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .cancel        (cancel),
        .load_valid    (load_valid),
        .load_ready    (load_ready),
        .load_count    (load_count),
        .busy          (busy),
        .remaining     (remaining),
        .expired_valid (expired_valid),
        .expired_ready (expired_ready)
    );

    always #5 clock = ~clock;

    // -------------------------------------------------------------------------
    // Behavioural model: "armed" means a deadline is outstanding, "fired"
    // means the deadline has passed and the event awaits acknowledge.
    // -------------------------------------------------------------------------
    typedef struct packed {
        logic        armed;
        logic        fired;
        logic [63:0] left;
        logic [63:0] period;
    } model_t;

    model_t m = '0;

    function automatic model_t model_step(model_t cur, logic lv, logic [W-1:0] lc,
                                          logic en, logic can, logic er);
        model_t nxt = cur;
        if (can) begin
            nxt.armed = 1'b0;
            nxt.fired = 1'b0;
            nxt.left  = 64'd0;
        end else if (cur.fired) begin
            if (er) begin
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
                nxt.left  = cur.period;
                nxt.fired = (cur.period == 64'd0);
`else
                nxt.armed = 1'b0;
                nxt.fired = 1'b0;
`endif
            end
        end else if (cur.armed) begin
            if (en) begin
                nxt.left  = cur.left - 64'd1;
                nxt.fired = (nxt.left == 64'd0);
            end
        end else if (lv) begin
            nxt.armed  = 1'b1;
            nxt.left   = 64'(lc);
            nxt.period = 64'(lc);
            nxt.fired  = (lc == '0);
        end
        return nxt;
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m <= '0;
        end else begin
            m <= model_step(m, load_valid, load_count, enable, cancel, expired_ready);
        end
    end

    // -------------------------------------------------------------------------
    // Checking
    // -------------------------------------------------------------------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: actual %0d expected %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge clock) begin
        check("model.load_ready",    64'(load_ready),    64'(!m.armed && !cancel));
        check("model.busy",          64'(busy),          64'(m.armed));
        check("model.expired_valid", 64'(expired_valid), 64'(m.fired));
        check("model.remaining",     64'(remaining),     m.left);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".load_ready"},    64'(load_ready),    64'd1);
        check({tag, ".busy"},          64'(busy),          64'd0);
        check({tag, ".remaining"},     64'(remaining),     64'd0);
        check({tag, ".expired_valid"}, 64'(expired_valid), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        // Reset held for 3 cycles.
        repeat (3) tick();
        check_idle("in_reset");
        reset = 1'b1;
        tick();
        check_idle("after_reset");

`ifndef COUNTDOWN_TIMER_AUTO_RELOAD_EN
        // Load 5, enable high, immediate acknowledge.
        enable        = 1'b1;
        expired_ready = 1'b1;
        load_valid    = 1'b1;
        load_count    = 5;
        tick();
        load_valid = 1'b0;
        check("load5.remaining0", 64'(remaining), 64'd5);
        check("load5.busy",       64'(busy),      64'd1);
        for (int k = 4; k >= 1; k--) begin
            tick();
            check("load5.remaining", 64'(remaining),     64'(k));
            check("load5.no_expiry", 64'(expired_valid), 64'd0);
        end
        tick();
        check("load5.expired",  64'(expired_valid), 64'd1);
        check("load5.rem_zero", 64'(remaining),     64'd0);
        tick();
        check_idle("load5.done");

        // Load 4 with enable toggling 1,0,1,0,... : expiry after 7 cycles.
        begin
            logic [W-1:0] exp_rem [7];
            exp_rem = '{3, 3, 2, 2, 1, 1, 0};
            load_valid = 1'b1;
            load_count = 4;
            tick();
            load_valid = 1'b0;
            check("load4.remaining0", 64'(remaining), 64'd4);
            for (int i = 1; i <= 7; i++) begin
                enable = (i % 2 == 1);
                tick();
                check("load4.remaining", 64'(remaining),     64'(exp_rem[i-1]));
                check("load4.expired",   64'(expired_valid), 64'(i == 7));
            end
            enable = 1'b1;
            tick();
            check_idle("load4.done");
        end

        // Load 0 with the acknowledge withheld for 10 cycles.
        expired_ready = 1'b0;
        load_valid    = 1'b1;
        load_count    = 0;
        tick();
        check("load0.expired",   64'(expired_valid), 64'd1);
        check("load0.remaining", 64'(remaining),     64'd0);
        load_count = 9;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("load0.held",    64'(expired_valid), 64'd1);
            check("load0.refused", 64'(load_ready),    64'd0);
        end
        load_valid    = 1'b0;
        expired_ready = 1'b1;
        tick();
        check_idle("load0.done");

        // Load 3, cancel when remaining = 1.
        load_valid = 1'b1;
        load_count = 3;
        tick();
        load_valid = 1'b0;
        tick();
        tick();
        check("cancel.remaining1", 64'(remaining), 64'd1);
        cancel = 1'b1;
        tick();
        check("cancel.busy",      64'(busy),          64'd0);
        check("cancel.remaining", 64'(remaining),     64'd0);
        check("cancel.no_expiry", 64'(expired_valid), 64'd0);
        // Load request together with cancel in IDLE must be refused.
        load_valid = 1'b1;
        load_count = 7;
        #1;
        check("cancel.load_ready", 64'(load_ready), 64'd0);
        tick();
        check("cancel.no_load", 64'(busy), 64'd0);
        cancel     = 1'b0;
        load_valid = 1'b0;
        tick();
        check_idle("cancel.done");
`else
        // Auto-reload: load 2, expiry every 3 cycles at +2, +5, +8.
        enable        = 1'b1;
        expired_ready = 1'b1;
        load_valid    = 1'b1;
        load_count    = 2;
        tick();
        load_valid = 1'b0;
        check("reload.remaining0", 64'(remaining), 64'd2);
        for (int i = 1; i <= 9; i++) begin
            tick();
            check("reload.pulse",      64'(expired_valid), 64'(i % 3 == 2));
            check("reload.load_ready", 64'(load_ready),    64'd0);
        end
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("reload.cancel_busy", 64'(busy), 64'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("reload.no_pulse", 64'(expired_valid), 64'd0);
        end
        check_idle("reload.done");
`endif

        // Reset asserted mid-count clears everything asynchronously.
        enable     = 1'b1;
        load_valid = 1'b1;
        load_count = 100;
        tick();
        load_valid = 1'b0;
        repeat (3) tick();
        check("areset.counting", 64'(remaining), 64'd97);
        #2;
        reset = 1'b0;
        #1;
        check_idle("areset.immediate");
        repeat (2) tick();
        reset = 1'b1;
        repeat (2) tick();
        check_idle("areset.stays_idle");

        // Randomized phase, checked against the model every cycle.
        for (int i = 0; i < 3000; i++) begin
            load_valid    = ($urandom_range(0, 9) < 3);
            load_count    = ($urandom_range(0, 19) == 0) ? W'($urandom)
                                                         : W'($urandom_range(0, 8));
            enable        = ($urandom_range(0, 3) != 0);
            cancel        = ($urandom_range(0, 39) == 0);
            expired_ready = ($urandom_range(0, 9) < 4);
            tick();
        end

        cancel     = 1'b0;
        load_valid = 1'b0;
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
